// File: rtl/div_result_uart_tx.sv
// div_result_uart_tx: sends each divider result as a 3-byte 8N1 UART frame
// (0xA5 sync, quotient, remainder), LSB first, idle-high line.
// Ports: clk, rst (async, active-low), i_start/i_q/i_r (divider result strobe),
//        o_txd (serial out), o_busy (frame in progress), o_done (end-of-frame pulse).
module div_result_uart_tx #(
    parameter int clk_freq       = 50000000,
    parameter int uart_baud_rate = 115200,
    parameter int p_N            = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic [p_N-1:0] i_q,
    input  logic [p_N-1:0] i_r,
    output logic           o_txd,
    output logic           o_busy,
    output logic           o_done
);

    localparam int DIV_RAW = clk_freq / uart_baud_rate;
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int CW      = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [7:0]    SYNC     = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      byte_idx, byte_n;
    logic [2:0]      bit_idx, bit_n;
    logic [2:0][7:0] frame_q, frame_n;
    logic            txd_n, busy_n, done_n;
    logic            tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            frame_q  <= '0;
            o_txd    <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            byte_idx <= byte_n;
            bit_idx  <= bit_n;
            frame_q  <= frame_n;
            o_txd    <= txd_n;
            o_busy   <= busy_n;
            o_done   <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        byte_n  = byte_idx;
        bit_n   = bit_idx;
        frame_n = frame_q;
        done_n  = 1'b0;
        tick    = (cnt == CNT_LAST);

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (i_start) begin
                    frame_n[0] = SYNC;
                    frame_n[1] = 8'(i_q);
                    frame_n[2] = 8'(i_r);
                    byte_n     = '0;
                    bit_n      = '0;
                    state_n    = START;
                end
            end
            START: begin
                if (tick) begin
                    cnt_n   = '0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        bit_n   = '0;
                        state_n = STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_n = '0;
                    if (byte_idx != 2'd2) begin
                        byte_n  = byte_idx + 2'd1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level is derived from the next state so it is registered
        // together with the state change (start bit appears on the accept edge).
        unique case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = frame_n[byte_n][bit_n];
            default: txd_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_div_result_uart_tx.sv
// Testbench for div_result_uart_tx: scoreboard of expected frames checked
// by a UART decoding monitor, plus done/busy timing and reset checks.
module tb_div_result_uart_tx;

    localparam int DIV   = 43;
    localparam int FRAME = 30 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic [7:0] i_q;
    logic [7:0] i_r;
    logic       o_txd;
    logic       o_busy;
    logic       o_done;

    always #5 clk = ~clk;

    div_result_uart_tx #(
        .clk_freq(50000000),
        .uart_baud_rate(1152000),
        .p_N(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_start(i_start),
        .i_q(i_q),
        .i_r(i_r),
        .o_txd(o_txd),
        .o_busy(o_busy),
        .o_done(o_done)
    );

    typedef struct packed {
        int         e0;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } frame_t;

    frame_t sb[$];
    int     cyc = 0;
    int     tests = 0;
    int     fails = 0;
    int     done_count = 0;
    int     done_cyc = 0;
    int     busy_cnt = 0;
    logic   done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic logic [7:0] get_byte(input logic [29:0] bits, input int b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = bits[10*b+1+i];
        return r;
    endfunction

    // Decode one 30-bit frame starting at the current negedge; abort on reset.
    task automatic decode_frame();
        logic [29:0] bits;
        logic        v;
        bit          glitch;
        int          sc;
        int          frm_ok;
        frame_t      e;
        v      = 1'b1;
        glitch = 1'b0;
        sc     = cyc;
        for (int k = 0; k < 30; k++) begin
            for (int j = 0; j < DIV; j++) begin
                if (k != 0 || j != 0) @(negedge clk);
                if (!rst) return;
                if (j == 0) v = o_txd;
                else if (o_txd !== v) glitch = 1'b1;
            end
            bits[k] = v;
        end
        check("frame_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            frm_ok = 1;
            for (int b = 0; b < 3; b++)
                if (bits[10*b] !== 1'b0 || bits[10*b+9] !== 1'b1) frm_ok = 0;
            check("start_cycle", sc, e.e0);
            check("byte0_sync", int'(get_byte(bits, 0)), int'(e.b0));
            check("byte1_quot", int'(get_byte(bits, 1)), int'(e.b1));
            check("byte2_rem", int'(get_byte(bits, 2)), int'(e.b2));
            check("start_stop_bits", frm_ok, 1);
            check("bit_width_43", int'(glitch), 0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && o_txd === 1'b0) decode_frame();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (o_busy === 1'b1) busy_cnt++;
            if (o_done === 1'b1) begin
                check("done_one_cycle", int'(done_prev), 0);
                done_count++;
                done_cyc = cyc;
            end
            done_prev = o_done;
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    // Drive a one-cycle strobe from the current negedge; E0 is the next posedge.
    task automatic issue(input logic [7:0] q, input logic [7:0] r,
                         input bit push, output int e0);
        frame_t f;
        i_start = 1'b1;
        i_q     = q;
        i_r     = r;
        e0      = cyc + 1;
        if (push) begin
            f.e0 = e0;
            f.b0 = 8'hA5;
            f.b1 = q;
            f.b2 = r;
            sb.push_back(f);
        end
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_neg(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int e0, e1, t, d0, b0;
        rst     = 1'b1;
        i_start = 1'b0;
        i_q     = '0;
        i_r     = '0;
        #2 rst = 1'b0;
        #1;
        check("reset_txd", int'(o_txd), 1);
        check("reset_busy", int'(o_busy), 0);
        check("reset_done", int'(o_done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Basic frame: 14/7
        d0 = done_count;
        b0 = busy_cnt;
        issue(8'h02, 8'h00, 1'b1, e0);
        wait_neg(e0 + FRAME + 5);
        check("basic_done_count", done_count - d0, 1);
        check("basic_done_time", done_cyc - e0, FRAME);
        check("basic_busy_cycles", busy_cnt - b0, FRAME);

        // Data pattern
        issue(8'hFF, 8'h55, 1'b1, e0);
        wait_neg(e0 + FRAME + 5);

        // Ignored starts: mid-frame and on the frame-end edge
        d0 = done_count;
        issue(8'h03, 8'h01, 1'b1, e0);
        wait_neg(e0 + 499);
        issue(8'h09, 8'h04, 1'b0, t);
        wait_neg(e0 + FRAME - 1);
        issue(8'h09, 8'h04, 1'b0, t);
        wait_neg(e0 + 2 * FRAME);
        check("ignored_done_count", done_count - d0, 1);
        check("ignored_line_idle", int'(o_txd), 1);
        check("ignored_not_busy", int'(o_busy), 0);

        // Back-to-back: second start at E0+1291
        d0 = done_count;
        issue(8'h11, 8'h22, 1'b1, e0);
        wait_neg(e0 + FRAME);
        issue(8'h33, 8'h44, 1'b1, e1);
        wait_neg(e1 + FRAME + 5);
        check("b2b_done_count", done_count - d0, 2);

        // Reset mid-frame, then start on the release edge
        d0 = done_count;
        issue(8'h12, 8'h34, 1'b0, e0);
        wait_neg(e0 + 699);
        rst = 1'b0;
        #1;
        check("midrst_txd", int'(o_txd), 1);
        check("midrst_busy", int'(o_busy), 0);
        check("midrst_done", int'(o_done), 0);
        repeat (3) @(negedge clk);
        check("midrst_hold_busy", int'(o_busy), 0);
        rst = 1'b1;
        check("midrst_no_done", done_count - d0, 0);
        issue(8'h5A, 8'hC3, 1'b1, e0);
        wait_neg(e0 + FRAME + 5);
        check("midrst_new_frame_done", done_count - d0, 1);

        // Capture isolation: inputs scrambled every cycle after E0
        issue(8'h37, 8'h0E, 1'b1, e0);
        while (cyc < e0 + FRAME) begin
            i_q = 8'($urandom);
            i_r = 8'($urandom);
            @(negedge clk);
        end
        wait_neg(e0 + FRAME + 5);

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_result_uart_tx.md
# div_result_uart_tx

Serializer stage directly downstream of the 8-bit divider in `system`. When the divider signals a finished result, it captures quotient and remainder. It then transmits them on a UART TX line as a three-byte 8N1 frame: sync byte 0xA5, then quotient, then remainder. The host side can then read every division result without probing internal nets.

## Interface
- `clk_freq`, 50000000, system clock frequency in Hz
- `uart_baud_rate`, 115200, serial bit rate
- `p_N`, 8, divider operand width; legal range 1..8; operands are zero-extended to 8 bits on the wire

- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `i_start`  in  1  one-cycle strobe from divider: `i_q`/`i_r` valid this cycle
- `i_q`  in  p_N  quotient
- `i_r`  in  p_N  remainder
- `o_txd`  out  1  UART serial output, idle high
- `o_busy`  out  1  frame in progress; `i_start` ignored while high
- `o_done`  out  1  one-cycle pulse at end of frame

## Operation
- Bit period DIV = max(2, clk_freq / uart_baud_rate), using integer truncation.
  - Bench values: 50 MHz / 1152000 → DIV = 43.
- Baud counter width is ceil(log2(DIV)). It counts 0..DIV-1 and reloads 0 on each bit boundary.
- FSM states:
  - IDLE:
    - `o_txd`=1, `o_busy`=0.
    - If `i_start`=1, latch {0xA5, zext(`i_q`), zext(`i_r`)} into a 3-byte buffer, clear byte index and bit index, then go to START.
  - START: `o_txd`=0 for DIV cycles, then go to DATA.
  - DATA:
    - Drive current byte bit[bit index], LSB first, for DIV cycles each.
    - After bit 7, go to STOP.
  - STOP:
    - `o_txd`=1 for DIV cycles.
    - If byte index < 2: increment byte index and go to START. There is no idle gap between bytes.
    - Else: go to IDLE and pulse `o_done`.
- Input capture:
  - Captured values are held internally for the whole frame.
  - Changes on `i_q`/`i_r` after capture have no effect.
- `i_start` handling:
  - `i_start` is sampled only in IDLE.
  - A strobe while busy is dropped, not queued. A strobe on the same edge the frame ends is also dropped.
- Reset (`rst`=0), at any time including mid-frame:
  - Immediately force `o_txd`=1, `o_busy`=0, `o_done`=0.
  - FSM goes to IDLE, counters go to 0, buffer goes to 0.
  - No partial frame is resumed after reset release.
- All outputs are registered, with no combinational path from inputs to outputs.

## Timing
- Let E0 be the rising edge where `i_start`=1 is sampled in IDLE.
  - At E0: `o_busy`→1 and `o_txd`→0 (start bit of byte 0).
- Frame is 30 bits: 3 × (start + 8 data + stop).
  - Wire bit k (0..29) is valid from edge E0+k·DIV to E0+(k+1)·DIV.
- At edge E0+30·DIV: `o_busy`→0, `o_done`→1.
- At edge E0+30·DIV+1: `o_done`→0.
  - Earliest next accepted `i_start` is sampled at this edge.
- Minimum spacing between accepted starts is 30·DIV+1 cycles.
- Reset release: first edge with `rst`=1 finds the block in IDLE. `i_start` on that edge is accepted.

## Test plan
- Basic frame (DIV=43):
  - Stimulus: `i_q`=2, `i_r`=0 (14/7), one-cycle `i_start`.
  - Response:
    - `o_txd` decodes as 0xA5, 0x02, 0x00, each with start=0 and stop=1.
    - Each bit lasts exactly 43 cycles.
    - `o_done` pulses once, 1290 cycles after E0.
    - `o_busy` is high for exactly 1290 cycles.
- Data pattern:
  - Stimulus: `i_q`=0xFF, `i_r`=0x55.
  - Response: decoded bytes are 0xA5, 0xFF, 0x55. The LSB-first order is checked bit by bit.
- Ignored start:
  - Stimulus: second `i_start` (`i_q`=9) at E0+500, then a third at E0+1290 (same edge as frame end).
  - Response:
    - Only the first frame is sent.
    - Line stays high after the frame, with no second frame.
    - `o_done` count is 1.
- Back-to-back:
  - Stimulus: `i_start` at E0 and again at E0+1291.
  - Response:
    - Two complete frames.
    - Second start bit begins at E0+1291.
- Reset mid-frame:
  - Stimulus: assert `rst`=0 at E0+700 (inside the quotient byte) for 3 cycles.
  - Response:
    - `o_txd`=1 and `o_busy`=0 with no clock edge needed.
    - No `o_done`.
    - A new `i_start` after release produces a full correct frame.
- Capture isolation:
  - Stimulus: change `i_q`/`i_r` every cycle after E0.
  - Response: transmitted bytes equal the values present at E0.
